pma_table_checker: RTL and testbench

PMA_TABLE_CHECKER -- requirements
Module: pma_table_checker

---
 rtl/pma_table_checker.sv | 178 +++++++++++++++++
 tb/tb_pma_table_checker.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_table_checker.sv
// Physical memory attribute checker: programmable region table, lowest-index-wins
// lookup of both ends of an access, registered response and sticky fault record.
module pma_table_checker #(
    parameter int PA_BITS  = 56,
    parameter int NREGIONS = 8,
    parameter int IDXW     = $clog2(NREGIONS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CfgWrEn,
    input  logic [IDXW-1:0]    CfgIdx,
    input  logic [PA_BITS-1:0] CfgBase,
    input  logic [5:0]         CfgSizeLog2,
    input  logic [6:0]         CfgAttr,
    input  logic               CfgValid,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [PA_BITS-1:0] PhysicalAddress,
    input  logic [1:0]         Size,
    input  logic               ReadAccess,
    input  logic               WriteAccess,
    input  logic               ExecuteAccess,
    input  logic               AtomicAccess,
    input  logic [3:0]         CMOp,
    input  logic [1:0]         PBMemoryType,
    output logic               RspValid,
    input  logic               RspReady,
    output logic               Cacheable,
    output logic               Idempotent,
    output logic               RegionHit,
    output logic [IDXW-1:0]    RegionIdx,
    output logic               InstrAccessFault,
    output logic               LoadAccessFault,
    output logic               StoreAmoAccessFault,
    output logic               FaultValid,
    output logic [PA_BITS-1:0] FaultAddr,
    output logic [1:0]         FaultCause,
    output logic               FaultOverflow,
    input  logic               FaultClr
);
    logic [PA_BITS-1:0]  baseReg     [NREGIONS];
    logic [5:0]          sizeLog2Reg [NREGIONS];
    logic [6:0]          attrReg     [NREGIONS];
    logic [NREGIONS-1:0] validReg;

    logic [NREGIONS-1:0] startMatch;
    logic [NREGIONS-1:0] endMatch;
    logic [PA_BITS-1:0]  endAddress;
    logic [IDXW-1:0]     startIdx;
    logic [IDXW-1:0]     endIdx;
    logic                startAny;
    logic                endAny;
    logic                hitNext;
    logic [6:0]          winAttr;
    logic                writeLike;
    logic                faultNext;
    logic                instrFaultNext;
    logic                loadFaultNext;
    logic                storeFaultNext;
    logic                anyFaultNext;
    logic [1:0]          causeNext;
    logic                accept;

    assign endAddress = PhysicalAddress + PA_BITS'((8'd1 << Size) - 8'd1);

    genvar gi;
    generate
        for (gi = 0; gi < NREGIONS; gi++) begin : gRegion
            logic [PA_BITS-1:0] regionMask;
            assign regionMask      = {PA_BITS{1'b1}} << sizeLog2Reg[gi];
            assign startMatch[gi]  = validReg[gi] &&
                ((PhysicalAddress & regionMask) == (baseReg[gi] & regionMask));
            assign endMatch[gi]    = validReg[gi] &&
                ((endAddress & regionMask) == (baseReg[gi] & regionMask));
        end
    endgenerate

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        startIdx = '0;
        startAny = 1'b0;
        endIdx   = '0;
        endAny   = 1'b0;
        for (int i = NREGIONS - 1; i >= 0; i--) begin
            if (startMatch[i]) begin
                startIdx = IDXW'(i);
                startAny = 1'b1;
            end
            if (endMatch[i]) begin
                endIdx = IDXW'(i);
                endAny = 1'b1;
            end
        end
    end

    // attr bits: [6]L [5]I [4]C [3]A [2]X [1]W [0]R
    assign hitNext        = startAny && endAny && (startIdx == endIdx);
    assign winAttr        = hitNext ? attrReg[startIdx] : 7'd0;
    assign writeLike      = WriteAccess || (CMOp != 4'd0);
    assign faultNext      = !hitNext || (ReadAccess && !winAttr[0]) ||
                            (writeLike && !winAttr[1]) ||
                            (ExecuteAccess && !winAttr[2]) ||
                            (AtomicAccess && !winAttr[3]);
    assign instrFaultNext = ExecuteAccess && faultNext;
    assign loadFaultNext  = ReadAccess && !WriteAccess && faultNext;
    assign storeFaultNext = writeLike && faultNext;
    assign anyFaultNext   = instrFaultNext || loadFaultNext || storeFaultNext;
    assign causeNext      = storeFaultNext ? 2'b11 : (loadFaultNext ? 2'b10 : 2'b01);

    assign ReqReady = !RspValid || RspReady;
    assign accept   = ReqValid && ReqReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGIONS; i++) begin
                baseReg[i]     <= '0;
                sizeLog2Reg[i] <= '0;
                attrReg[i]     <= '0;
            end
            validReg <= '0;
        end else if (CfgWrEn && (32'(CfgIdx) < 32'(NREGIONS)) && !attrReg[CfgIdx][6]) begin
            baseReg[CfgIdx]     <= CfgBase;
            sizeLog2Reg[CfgIdx] <= CfgSizeLog2;
            attrReg[CfgIdx]     <= CfgAttr;
            validReg[CfgIdx]    <= CfgValid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RspValid            <= 1'b0;
            Cacheable           <= 1'b0;
            Idempotent          <= 1'b0;
            RegionHit           <= 1'b0;
            RegionIdx           <= '0;
            InstrAccessFault    <= 1'b0;
            LoadAccessFault     <= 1'b0;
            StoreAmoAccessFault <= 1'b0;
            FaultValid          <= 1'b0;
            FaultAddr           <= '0;
            FaultCause          <= 2'b00;
            FaultOverflow       <= 1'b0;
        end else begin
            if (accept) begin
                RspValid            <= 1'b1;
                RegionHit           <= hitNext;
                RegionIdx           <= hitNext ? startIdx : '0;
                Cacheable           <= (PBMemoryType == 2'b00) && winAttr[4];
                Idempotent          <= (PBMemoryType == 2'b00) ? winAttr[5] : (PBMemoryType == 2'b01);
                InstrAccessFault    <= instrFaultNext;
                LoadAccessFault     <= loadFaultNext;
                StoreAmoAccessFault <= storeFaultNext;
            end else if (RspReady) begin
                RspValid <= 1'b0;
            end

            // A clear that coincides with a new fault hands the record to the new fault.
            if (FaultClr) begin
                FaultOverflow <= 1'b0;
                if (accept && anyFaultNext) begin
                    FaultValid <= 1'b1;
                    FaultAddr  <= PhysicalAddress;
                    FaultCause <= causeNext;
                end else begin
                    FaultValid <= 1'b0;
                end
            end else if (accept && anyFaultNext) begin
                if (FaultValid) begin
                    FaultOverflow <= 1'b1;
                end else begin
                    FaultValid <= 1'b1;
                    FaultAddr  <= PhysicalAddress;
                    FaultCause <= causeNext;
                end
            end
        end
    end
endmodule

// File: tb/tb_pma_table_checker.sv
// Bench for pma_table_checker: directed vector table, hand-written corner sequences,
// then random config/requests checked against an address-range model.
module tb_pma_table_checker;
    localparam int PA_BITS  = 56;
    localparam int NREGIONS = 8;
    localparam int IDXW     = 3;
    localparam logic [63:0] PAMASK = (64'd1 << PA_BITS) - 64'd1;

    logic               clk = 1'b0;
    logic               reset;
    logic               CfgWrEn;
    logic [IDXW-1:0]    CfgIdx;
    logic [PA_BITS-1:0] CfgBase;
    logic [5:0]         CfgSizeLog2;
    logic [6:0]         CfgAttr;
    logic               CfgValid;
    logic               ReqValid;
    logic               ReqReady;
    logic [PA_BITS-1:0] PhysicalAddress;
    logic [1:0]         Size;
    logic               ReadAccess, WriteAccess, ExecuteAccess, AtomicAccess;
    logic [3:0]         CMOp;
    logic [1:0]         PBMemoryType;
    logic               RspValid;
    logic               RspReady;
    logic               Cacheable, Idempotent, RegionHit;
    logic [IDXW-1:0]    RegionIdx;
    logic               InstrAccessFault, LoadAccessFault, StoreAmoAccessFault;
    logic               FaultValid;
    logic [PA_BITS-1:0] FaultAddr;
    logic [1:0]         FaultCause;
    logic               FaultOverflow;
    logic               FaultClr;

    always #5 clk = ~clk;

    pma_table_checker #(.PA_BITS(PA_BITS), .NREGIONS(NREGIONS), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset),
        .CfgWrEn(CfgWrEn), .CfgIdx(CfgIdx), .CfgBase(CfgBase), .CfgSizeLog2(CfgSizeLog2),
        .CfgAttr(CfgAttr), .CfgValid(CfgValid),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .PhysicalAddress(PhysicalAddress), .Size(Size),
        .ReadAccess(ReadAccess), .WriteAccess(WriteAccess), .ExecuteAccess(ExecuteAccess),
        .AtomicAccess(AtomicAccess), .CMOp(CMOp), .PBMemoryType(PBMemoryType),
        .RspValid(RspValid), .RspReady(RspReady),
        .Cacheable(Cacheable), .Idempotent(Idempotent), .RegionHit(RegionHit), .RegionIdx(RegionIdx),
        .InstrAccessFault(InstrAccessFault), .LoadAccessFault(LoadAccessFault),
        .StoreAmoAccessFault(StoreAmoAccessFault),
        .FaultValid(FaultValid), .FaultAddr(FaultAddr), .FaultCause(FaultCause),
        .FaultOverflow(FaultOverflow), .FaultClr(FaultClr)
    );

    typedef struct {
        logic            hit;
        logic [IDXW-1:0] idx;
        logic            cach;
        logic            idem;
        logic            iaf;
        logic            laf;
        logic            saf;
    } resp_t;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic [1:0]  sz;
        logic [3:0]  acc;   // {read, write, execute, atomic}
        logic [3:0]  cmo;
        logic [1:0]  pb;
        resp_t       exp;
    } vec_t;

    // Reference table and fault record
    logic [63:0] mBase  [NREGIONS];
    int          mSize  [NREGIONS];
    logic [6:0]  mAttr  [NREGIONS];
    logic        mValid [NREGIONS];
    logic        mFV, mFO;
    logic [63:0] mFA;
    logic [1:0]  mFC;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGIONS; i++) begin
            mBase[i] = 0; mSize[i] = 0; mAttr[i] = 0; mValid[i] = 1'b0;
        end
        mFV = 1'b0; mFO = 1'b0; mFA = 0; mFC = 2'b00;
    endtask

    task automatic modelCfg(input int idx, input logic [63:0] base, input int sz,
                            input logic [6:0] attr, input logic v);
        if (!mAttr[idx][6]) begin
            mBase[idx] = base & PAMASK; mSize[idx] = sz; mAttr[idx] = attr; mValid[idx] = v;
        end
    endtask

    // Region i spans every address whose upper bits above its size equal the base's.
    function automatic int winner(input logic [63:0] a);
        for (int i = 0; i < NREGIONS; i++)
            if (mValid[i] && ((a >> mSize[i]) == (mBase[i] >> mSize[i]))) return i;
        return -1;
    endfunction

    function automatic resp_t model(input logic [63:0] addr, input logic [1:0] sz,
                                    input logic [3:0] acc, input logic [3:0] cmo, input logic [1:0] pb);
        resp_t       r;
        logic [63:0] last;
        int          ws, we;
        logic [6:0]  at;
        logic        wl, f;
        last  = (addr + (64'd1 << sz) - 64'd1) & PAMASK;
        ws    = winner(addr);
        we    = winner(last);
        r.hit = (ws >= 0) && (ws == we);
        at    = r.hit ? mAttr[ws] : 7'd0;
        wl    = acc[2] || (cmo != 0);
        f     = !r.hit || (acc[3] && !at[0]) || (wl && !at[1]) || (acc[1] && !at[2]) || (acc[0] && !at[3]);
        r.idx  = r.hit ? IDXW'(ws) : '0;
        r.iaf  = acc[1] && f;
        r.laf  = acc[3] && !acc[2] && f;
        r.saf  = wl && f;
        r.cach = (pb == 2'b00) && r.hit && at[4];
        r.idem = (pb == 2'b00) ? (r.hit && at[5]) : (pb == 2'b01);
        return r;
    endfunction

    task automatic modelFault(input resp_t e, input logic [63:0] addr, input logic clr);
        logic       anyF;
        logic [1:0] cause;
        anyF  = e.iaf || e.laf || e.saf;
        cause = e.saf ? 2'b11 : (e.laf ? 2'b10 : 2'b01);
        if (clr) begin
            mFO = 1'b0;
            if (anyF) begin mFV = 1'b1; mFA = addr & PAMASK; mFC = cause; end
            else mFV = 1'b0;
        end else if (anyF) begin
            if (mFV) mFO = 1'b1;
            else begin mFV = 1'b1; mFA = addr & PAMASK; mFC = cause; end
        end
    endtask

    task automatic checkResp(input string t, input resp_t e);
        chk({t, ".rspvalid"}, RspValid, 1);
        chk({t, ".hit"}, RegionHit, e.hit);
        chk({t, ".idx"}, RegionIdx, e.idx);
        chk({t, ".cacheable"}, Cacheable, e.cach);
        chk({t, ".idempotent"}, Idempotent, e.idem);
        chk({t, ".iaf"}, InstrAccessFault, e.iaf);
        chk({t, ".laf"}, LoadAccessFault, e.laf);
        chk({t, ".saf"}, StoreAmoAccessFault, e.saf);
    endtask

    task automatic checkFault(input string t);
        chk({t, ".fvalid"}, FaultValid, mFV);
        chk({t, ".foverflow"}, FaultOverflow, mFO);
        chk({t, ".faddr"}, FaultAddr, mFA);
        chk({t, ".fcause"}, FaultCause, mFC);
    endtask

    task automatic checkResetState(input string t);
        chk({t, ".rspvalid"}, RspValid, 0);
        chk({t, ".reqready"}, ReqReady, 1);
        chk({t, ".hit"}, RegionHit, 0);
        chk({t, ".cacheable"}, Cacheable, 0);
        chk({t, ".laf"}, LoadAccessFault, 0);
        chk({t, ".fvalid"}, FaultValid, 0);
        chk({t, ".faddr"}, FaultAddr, 0);
        chk({t, ".foverflow"}, FaultOverflow, 0);
    endtask

    task automatic cfg(input int idx, input logic [63:0] base, input int sz,
                       input logic [6:0] attr, input logic v);
        CfgWrEn = 1'b1; CfgIdx = IDXW'(idx); CfgBase = base[PA_BITS-1:0];
        CfgSizeLog2 = 6'(sz); CfgAttr = attr; CfgValid = v;
        @(posedge clk); #1;
        CfgWrEn = 1'b0;
        modelCfg(idx, base, sz, attr, v);
        $display("cfg idx=%0d base=%h size=2^%0d attr=%b valid=%0d", idx, base, sz, attr, v);
    endtask

    task automatic driveReq(input logic [63:0] addr, input logic [1:0] sz, input logic [3:0] acc,
                            input logic [3:0] cmo, input logic [1:0] pb);
        PhysicalAddress = addr[PA_BITS-1:0]; Size = sz;
        ReadAccess = acc[3]; WriteAccess = acc[2]; ExecuteAccess = acc[1]; AtomicAccess = acc[0];
        CMOp = cmo; PBMemoryType = pb; ReqValid = 1'b1;
    endtask

    task automatic idleReq();
        ReqValid = 1'b0; ReadAccess = 0; WriteAccess = 0; ExecuteAccess = 0; AtomicAccess = 0;
        CMOp = 0; PBMemoryType = 0; FaultClr = 1'b0;
    endtask

    task automatic doReq(input string t, input logic [63:0] addr, input logic [1:0] sz,
                         input logic [3:0] acc, input logic [3:0] cmo, input logic [1:0] pb,
                         input logic clr, output resp_t e);
        driveReq(addr, sz, acc, cmo, pb);
        RspReady = 1'b1; FaultClr = clr;
        e = model(addr, sz, acc, cmo, pb);
        @(posedge clk); #1;
        idleReq();
        modelFault(e, addr, clr);
        $display("req %s addr=%h sz=%0d acc=%b cmo=%0d pb=%0d clr=%0d -> hit=%0d idx=%0d flt=%b%b%b fv=%0d fo=%0d",
                 t, addr, sz, acc, cmo, pb, clr, RegionHit, RegionIdx,
                 InstrAccessFault, LoadAccessFault, StoreAmoAccessFault, FaultValid, FaultOverflow);
    endtask

    function automatic vec_t mk(input string n, input logic [63:0] a, input logic [1:0] sz,
                                input logic [3:0] acc, input logic [3:0] cmo, input logic [1:0] pb,
                                input logic hit, input int idx, input logic c, input logic i,
                                input logic [2:0] flt);
        vec_t v;
        v.name = n; v.addr = a; v.sz = sz; v.acc = acc; v.cmo = cmo; v.pb = pb;
        v.exp.hit = hit; v.exp.idx = IDXW'(idx); v.exp.cach = c; v.exp.idem = i;
        v.exp.iaf = flt[2]; v.exp.laf = flt[1]; v.exp.saf = flt[0];
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        resp_t       e, e2;
        logic [63:0] a;
        logic [63:0] aligned;
        int          j, s;
        logic [3:0]  acc;

        reset = 1'b1; CfgWrEn = 1'b0; CfgIdx = 0; CfgBase = 0; CfgSizeLog2 = 0; CfgAttr = 0; CfgValid = 0;
        PhysicalAddress = 0; Size = 0; RspReady = 1'b1;
        idleReq();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;

        cfg(0, 64'h8000_0000, 20, 7'h1F, 1'b1);   // RWXAC
        cfg(1, 64'h1000_0000, 12, 7'h03, 1'b1);   // RW
        cfg(2, 64'h8000_0000, 24, 7'h23, 1'b1);   // RW + idempotent, shadows beyond entry 0

        //                name         addr                 sz acc      cmo pb hit idx c  i  {iaf,laf,saf}
        vecs.push_back(mk("rd_hit",   64'h8000_0010,       3, 4'b1000, 0, 0, 1, 0, 1, 0, 3'b000));
        vecs.push_back(mk("rd_cross", 64'h800F_FFFC,       3, 4'b1000, 0, 0, 0, 0, 0, 0, 3'b010));
        vecs.push_back(mk("amo_noa",  64'h1000_0000,       2, 4'b0101, 0, 0, 1, 1, 0, 0, 3'b001));
        vecs.push_back(mk("ex_nox",   64'h1000_0004,       2, 4'b0010, 0, 0, 1, 1, 0, 0, 3'b100));
        vecs.push_back(mk("rd_top",   64'h1000_0FFC,       2, 4'b1000, 0, 0, 1, 1, 0, 0, 3'b000));
        vecs.push_back(mk("rd_over",  64'h1000_0FFD,       2, 4'b1000, 0, 0, 0, 0, 0, 0, 3'b010));
        vecs.push_back(mk("rd_e2",    64'h8020_0000,       0, 4'b1000, 0, 0, 1, 2, 0, 1, 3'b000));
        vecs.push_back(mk("ex_e2",    64'h8020_0000,       1, 4'b0010, 0, 0, 1, 2, 0, 1, 3'b100));
        vecs.push_back(mk("cmo_ok",   64'h8000_0000,       0, 4'b0000, 1, 0, 1, 0, 1, 0, 3'b000));
        vecs.push_back(mk("cmo_miss", 64'h2000_0000,       0, 4'b0000, 4, 0, 0, 0, 0, 0, 3'b001));
        vecs.push_back(mk("noacc",    64'h2000_0000,       3, 4'b0000, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk("pb_io",    64'h8000_0010,       3, 4'b1000, 0, 2, 1, 0, 0, 0, 3'b000));
        vecs.push_back(mk("pb_nc",    64'h8000_0010,       3, 4'b1000, 0, 1, 1, 0, 0, 1, 3'b000));
        vecs.push_back(mk("rw_hit",   64'h8000_0000,       3, 4'b1100, 0, 0, 1, 0, 1, 0, 3'b000));
        vecs.push_back(mk("rd_wrap",  64'hFF_FFFF_FFFF_FFFC, 3, 4'b1000, 0, 0, 0, 0, 0, 0, 3'b010));

        foreach (vecs[k]) begin
            doReq(vecs[k].name, vecs[k].addr, vecs[k].sz, vecs[k].acc, vecs[k].cmo, vecs[k].pb, 1'b0, e);
            checkResp(vecs[k].name, vecs[k].exp);
            checkFault(vecs[k].name);
        end

        // Fault record: capture, overflow, clear coincident with a new fault
        FaultClr = 1'b1;
        @(posedge clk); #1;
        FaultClr = 1'b0;
        e = '{default: 0};
        modelFault(e, 0, 1'b1);
        chk("clr.fvalid", FaultValid, 0);
        chk("clr.foverflow", FaultOverflow, 0);
        doReq("cap_load", 64'h800F_FFFC, 3, 4'b1000, 0, 0, 1'b0, e);
        chk("cap_load.laf", LoadAccessFault, 1);
        chk("cap_load.fvalid", FaultValid, 1);
        chk("cap_load.faddr", FaultAddr, 64'h800F_FFFC);
        chk("cap_load.fcause", FaultCause, 2'b10);
        chk("cap_load.foverflow", FaultOverflow, 0);
        doReq("ovf_amo", 64'h1000_0000, 2, 4'b0101, 0, 0, 1'b0, e);
        chk("ovf_amo.saf", StoreAmoAccessFault, 1);
        chk("ovf_amo.cacheable", Cacheable, 0);
        chk("ovf_amo.foverflow", FaultOverflow, 1);
        chk("ovf_amo.faddr", FaultAddr, 64'h800F_FFFC);
        chk("ovf_amo.fcause", FaultCause, 2'b10);
        doReq("clr_new", 64'h1000_0004, 2, 4'b0010, 0, 0, 1'b1, e);
        chk("clr_new.fvalid", FaultValid, 1);
        chk("clr_new.faddr", FaultAddr, 64'h1000_0004);
        chk("clr_new.fcause", FaultCause, 2'b01);
        chk("clr_new.foverflow", FaultOverflow, 0);

        // Backpressure: response must hold while not consumed
        doReq("bp1", 64'h8000_0010, 3, 4'b1000, 0, 0, 1'b0, e);
        RspReady = 1'b0;
        driveReq(64'h1000_0000, 0, 4'b1000, 0, 0);
        e2 = model(64'h1000_0000, 0, 4'b1000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp.reqready", ReqReady, 0);
            chk("bp.rspvalid", RspValid, 1);
            chk("bp.idx", RegionIdx, 0);
            chk("bp.cacheable", Cacheable, 1);
        end
        RspReady = 1'b1;
        #1;
        chk("bp.release_ready", ReqReady, 1);
        @(posedge clk); #1;
        idleReq();
        modelFault(e2, 64'h1000_0000, 1'b0);
        $display("req bp2 addr=%h accepted after release -> idx=%0d", 64'h1000_0000, RegionIdx);
        chk("bp2.rspvalid", RspValid, 1);
        chk("bp2.hit", RegionHit, 1);
        chk("bp2.idx", RegionIdx, 1);
        chk("bp2.cacheable", Cacheable, 0);
        @(posedge clk); #1;
        chk("bp2.drain", RspValid, 0);

        // Config write coincident with acceptance does not affect that lookup
        CfgWrEn = 1'b1; CfgIdx = 3; CfgBase = 56'h2000_0000; CfgSizeLog2 = 12; CfgAttr = 7'h03; CfgValid = 1'b1;
        driveReq(64'h2000_0000, 2, 4'b1000, 0, 0);
        e = model(64'h2000_0000, 2, 4'b1000, 0, 0);
        @(posedge clk); #1;
        CfgWrEn = 1'b0;
        idleReq();
        modelCfg(3, 64'h2000_0000, 12, 7'h03, 1'b1);
        modelFault(e, 64'h2000_0000, 1'b0);
        $display("req same_cycle addr=%h -> hit=%0d", 64'h2000_0000, RegionHit);
        chk("same_cycle.hit", RegionHit, 0);
        chk("same_cycle.laf", LoadAccessFault, 1);
        doReq("after_cfg", 64'h2000_0000, 2, 4'b1000, 0, 0, 1'b0, e);
        chk("after_cfg.hit", RegionHit, 1);
        chk("after_cfg.idx", RegionIdx, 3);
        chk("after_cfg.laf", LoadAccessFault, 0);

        // Locking, reset mid-operation
        cfg(0, 64'h8000_0000, 20, 7'h5F, 1'b1);
        cfg(0, 64'h0, 20, 7'h1F, 1'b1);
        doReq("locked_hit", 64'h8000_0010, 3, 4'b1000, 0, 0, 1'b0, e);
        chk("locked_hit.hit", RegionHit, 1);
        chk("locked_hit.idx", RegionIdx, 0);
        chk("locked_hit.laf", LoadAccessFault, 0);
        doReq("locked_low", 64'h0000_0010, 3, 4'b1000, 0, 0, 1'b0, e);
        chk("locked_low.hit", RegionHit, 0);
        chk("locked_low.laf", LoadAccessFault, 1);
        reset = 1'b1;
        driveReq(64'h0, 3, 4'b1000, 0, 0);
        @(posedge clk); #1;
        idleReq();
        modelReset();
        checkResetState("mid_reset");
        reset = 1'b0;
        doReq("post_reset", 64'h8000_0000, 3, 4'b1000, 0, 0, 1'b0, e);
        chk("post_reset.hit", RegionHit, 0);
        chk("post_reset.laf", LoadAccessFault, 1);
        chk("post_reset.faddr", FaultAddr, 64'h8000_0000);
        chk("post_reset.fcause", FaultCause, 2'b10);

        // Random configuration and traffic against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? {32'h0, $urandom_range(0, 3), 28'h0} : {$urandom, $urandom};
                s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 56)) : int'($urandom_range(3, 24));
                cfg(int'($urandom_range(0, NREGIONS - 1)), a & PAMASK, s,
                    {($urandom_range(0, 15) == 0), 6'($urandom)}, ($urandom_range(0, 4) != 0));
            end else begin
                j = int'($urandom_range(0, NREGIONS - 1));
                if (mValid[j] && $urandom_range(0, 2) != 0) begin
                    aligned = (mBase[j] >> mSize[j]) << mSize[j];
                    if ($urandom_range(0, 1) == 0)
                        a = aligned + ({$urandom, $urandom} & ((64'd1 << mSize[j]) - 64'd1));
                    else
                        a = aligned + (64'd1 << mSize[j]) - 64'($urandom_range(1, 8));
                end else begin
                    a = {$urandom, $urandom};
                end
                acc    = 4'($urandom);
                acc[0] = acc[0] && acc[2];
                doReq("rnd", a & PAMASK, 2'($urandom), acc,
                      ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0, 2'($urandom_range(0, 2)),
                      ($urandom_range(0, 7) == 0), e);
                checkResp("rnd", e);
                checkFault("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
